fp_stream_harness: RTL and testbench
====================================

Name: fp_stream_harness

Overview:
Parametrised successor to the fixed two-reader/operator/writer test harness, built as synthesizable RTL. It buffers two operand streams in independent FIFOs and pairs them. Each pair is issued to any two-input FP operator (multiplier, adder, divider) over stb/ack, and the result is forwarded downstream. In CHECK mode each result is compared against an expected-value stream, with a mismatch flag and saturating pass/error counters, so on-chip self-test replaces file-based checking.

Parameters:
WIDTH, 32, operand/result width; 32 (single) or 64 (double), exponent field 8 or 11 bits derived from it
DEPTH, 4, entries per operand FIFO; power of two, >= 2
CHECK, 1, 1 = consume expected stream and compare; 0 = pass-through, no compare

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
input_a  in  WIDTH  operand A data
input_a_stb  in  1  operand A valid
input_a_ack  out  1  operand A accepted
input_b  in  WIDTH  operand B data
input_b_stb  in  1  operand B valid
input_b_ack  out  1  operand B accepted
op_a  out  WIDTH  operator operand A
op_a_stb  out  1  operator A valid
op_a_ack  in  1  operator took A
op_b  out  WIDTH  operator operand B
op_b_stb  out  1  operator B valid
op_b_ack  in  1  operator took B
op_z  in  WIDTH  operator result
op_z_stb  in  1  operator result valid
op_z_ack  out  1  result accepted
input_e  in  WIDTH  expected result (ignored when CHECK=0)
input_e_stb  in  1  expected valid
input_e_ack  out  1  expected accepted
output_z  out  WIDTH  forwarded result
output_z_stb  out  1  result valid
output_z_ack  in  1  downstream took result
mismatch  out  1  compare failed; valid while output_z_stb=1
count_total  out  32  results delivered
count_err  out  32  results delivered with mismatch=1
busy  out  1  state != IDLE or either FIFO non-empty

Behaviour:
- Handshake: transfer on rising edge where stb=1 and ack=1. Sender holds data and stb until the transfer. All outputs except input_a_ack/input_b_ack are registered.
- Reset (rst=0, async): FIFOs flushed, state=IDLE. All registered outputs are 0: op_a, op_b, op_*_stb, op_z_ack, input_e_ack, output_z, output_z_stb, mismatch, counters.
- Reset mid-operation: any in-flight pair or result is discarded.
- FIFO A/B: input_x_ack = !full_x (combinational), so it is 1 immediately after reset.
  - Full: ack=0; no fall-through.
  - Push and pop in the same cycle are allowed when not full.
  - Order is preserved; pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND, WAIT_Z, WAIT_E, OUT.
  - IDLE: when both FIFOs are non-empty, load heads into op_a/op_b and set op_a_stb=op_b_stb=1 next cycle; go to SEND.
  - SEND: each stb drops independently on its own transfer. When both have transferred (same or different cycles), pop both FIFOs exactly once and go to WAIT_Z with op_z_ack=1.
  - WAIT_Z: on op_z transfer, latch the result and clear op_z_ack. If CHECK=1, go to WAIT_E with input_e_ack=1; otherwise go to OUT with mismatch=0.
  - WAIT_E: on input_e transfer, compute mismatch and go to OUT.
  - OUT: output_z_stb=1 until transfer, then IDLE. Minimum IDLE->IDLE loop is 1 cycle per state.
- Compare: mismatch = (z != e) bitwise, except when both are NaN (exponent all ones, mantissa != 0), which counts as equal. +0 vs -0 is a mismatch.
- Counters:
  - count_total increments on each output_z transfer.
  - count_err increments on the same transfer when mismatch=1.
  - Both saturate at 0xFFFFFFFF.
- input_e_ack is permanently 0 when CHECK=0.
- Unused op_z_stb outside WAIT_Z is ignored (op_z_ack=0).

Test Plan:
- WIDTH=32, CHECK=1: A=0x3FC00000, B=0x40000000, operator model returns 0x40400000, E=0x40400000 -> output_z=0x40400000, mismatch=0, count_total=1, count_err=0.
- Same operands, E=0x40400001 -> mismatch=1 with output_z_stb, count_err=1. Then op_z=0x7FC00000, E=0x7F800001 -> mismatch=0.
- DEPTH=4, op_a_ack held 0, push 5 A and 5 B -> input_a_ack/input_b_ack go 0 after the 4th accept. Release op_a_ack -> 5 results emerge in push order.
- op_a_ack on cycle n, op_b_ack on n+2 -> op_a_stb low from n+1, op_b_stb low from n+3; each FIFO decrements by exactly 1.
- rst pulsed low while in WAIT_Z with 2 entries queued -> all outputs 0 asynchronously, busy=0, counters 0; input_a_ack=1 on the first edge after release.
- CHECK=0, 3 pairs streamed with input_e_stb=1 -> input_e_ack never 1, mismatch always 0, count_total=3.

Source files
------------

// File: rtl/fp_stream_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_stream_fifo / fp_stream_harness                           |
// | Description : Operand-stream harness for any two-input FP operator.        |
// |               Two operand FIFOs are paired and issued over stb/ack. Each   |
// |               result is forwarded downstream. With CHECK=1 the result is   |
// |               also compared with an expected-value stream, and pass/error  |
// |               counters saturate at all ones.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | fp_stream_fifo ports                                                       |
// |   clk, rst           clock / async active-low reset                        |
// |   push_i, data_i     write request (ignored when full) and its data        |
// |   pop_i              drop the head entry (ignored when empty)              |
// |   full_o, empty_o    occupancy flags                                       |
// |   head_o             oldest entry, valid while !empty_o                    |
// | fp_stream_harness ports                                                    |
// |   input_a/_b         operand streams in (ack = FIFO not full)              |
// |   op_a/_b, op_z      operator issue and result handshakes                  |
// |   input_e            expected-result stream (CHECK=1 only)                 |
// |   output_z           forwarded result, with mismatch flag                  |
// |   count_total/_err   saturating delivered / mismatched result counters     |
// |   busy               FSM not idle, or either FIFO holds data               |
// +----------------------------------------------------------------------------+

module fp_stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_INC = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // One extra pointer bit tells full apart from empty when the indices meet.
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_INC;
         if (do_pop)  rd_q <= rd_q + PTR_INC;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

module fp_stream_harness #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter bit CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] input_a,
   input  logic             input_a_stb,
   output logic             input_a_ack,
   input  logic [WIDTH-1:0] input_b,
   input  logic             input_b_stb,
   output logic             input_b_ack,
   output logic [WIDTH-1:0] op_a,
   output logic             op_a_stb,
   input  logic             op_a_ack,
   output logic [WIDTH-1:0] op_b,
   output logic             op_b_stb,
   input  logic             op_b_ack,
   input  logic [WIDTH-1:0] op_z,
   input  logic             op_z_stb,
   output logic             op_z_ack,
   input  logic [WIDTH-1:0] input_e,
   input  logic             input_e_stb,
   output logic             input_e_ack,
   output logic [WIDTH-1:0] output_z,
   output logic             output_z_stb,
   input  logic             output_z_ack,
   output logic             mismatch,
   output logic [31:0]      count_total,
   output logic [31:0]      count_err,
   output logic             busy
);

   localparam int EXP_W = (WIDTH == 64) ? 11 : 8;
   localparam int MAN_W = WIDTH - 1 - EXP_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND   = 3'd1,
      WAIT_Z = 3'd2,
      WAIT_E = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             op_a_stb_q, op_a_stb_d;
   logic             op_b_stb_q, op_b_stb_d;
   logic             op_z_ack_q, op_z_ack_d;
   logic             input_e_ack_q, input_e_ack_d;
   logic [WIDTH-1:0] output_z_q, output_z_d;
   logic             output_z_stb_q, output_z_stb_d;
   logic             mismatch_q, mismatch_d;
   logic [31:0]      count_total_q, count_total_d;
   logic [31:0]      count_err_q, count_err_d;

   logic             full_a, empty_a, full_b, empty_b;
   logic [WIDTH-1:0] head_a, head_b;
   logic             pop;
   logic             a_done, b_done;
   logic             nan_z, nan_e, differs;

   fp_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk     (clk),
      .rst     (rst),
      .push_i  (input_a_stb),
      .data_i  (input_a),
      .pop_i   (pop),
      .full_o  (full_a),
      .empty_o (empty_a),
      .head_o  (head_a)
   );

   fp_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk     (clk),
      .rst     (rst),
      .push_i  (input_b_stb),
      .data_i  (input_b),
      .pop_i   (pop),
      .full_o  (full_b),
      .empty_o (empty_b),
      .head_o  (head_b)
   );

   assign input_a_ack = !full_a;
   assign input_b_ack = !full_b;

   // The latched result lives in output_z_q from WAIT_Z onwards; two NaNs of
   // any payload compare equal, every other bit difference (incl. +0/-0) does not.
   assign nan_z   = (&output_z_q[WIDTH-2 -: EXP_W]) && (|output_z_q[MAN_W-1:0]);
   assign nan_e   = (&input_e[WIDTH-2 -: EXP_W]) && (|input_e[MAN_W-1:0]);
   assign differs = (output_z_q != input_e) && !(nan_z && nan_e);

   always_comb begin
      state_d        = state_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      op_a_stb_d     = op_a_stb_q;
      op_b_stb_d     = op_b_stb_q;
      op_z_ack_d     = op_z_ack_q;
      input_e_ack_d  = input_e_ack_q;
      output_z_d     = output_z_q;
      output_z_stb_d = output_z_stb_q;
      mismatch_d     = mismatch_q;
      count_total_d  = count_total_q;
      count_err_d    = count_err_q;
      pop            = 1'b0;
      a_done         = 1'b0;
      b_done         = 1'b0;

      case (state_q)
         IDLE: begin
            // Heads are copied but not popped until the operator has both.
            if (!empty_a && !empty_b) begin
               op_a_d     = head_a;
               op_b_d     = head_b;
               op_a_stb_d = 1'b1;
               op_b_stb_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            a_done = !op_a_stb_q || op_a_ack;
            b_done = !op_b_stb_q || op_b_ack;
            if (op_a_stb_q && op_a_ack) op_a_stb_d = 1'b0;
            if (op_b_stb_q && op_b_ack) op_b_stb_d = 1'b0;
            if (a_done && b_done) begin
               pop        = 1'b1;
               op_z_ack_d = 1'b1;
               state_d    = WAIT_Z;
            end
         end
         WAIT_Z: begin
            if (op_z_stb) begin
               output_z_d = op_z;
               op_z_ack_d = 1'b0;
               if (CHECK) begin
                  input_e_ack_d = 1'b1;
                  state_d       = WAIT_E;
               end else begin
                  mismatch_d     = 1'b0;
                  output_z_stb_d = 1'b1;
                  state_d        = OUT;
               end
            end
         end
         WAIT_E: begin
            if (input_e_stb) begin
               input_e_ack_d  = 1'b0;
               mismatch_d     = differs;
               output_z_stb_d = 1'b1;
               state_d        = OUT;
            end
         end
         OUT: begin
            if (output_z_ack) begin
               output_z_stb_d = 1'b0;
               state_d        = IDLE;
               if (count_total_q != '1) count_total_d = count_total_q + 32'd1;
               if (mismatch_q && (count_err_q != '1)) count_err_d = count_err_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         op_a_q         <= '0;
         op_b_q         <= '0;
         op_a_stb_q     <= 1'b0;
         op_b_stb_q     <= 1'b0;
         op_z_ack_q     <= 1'b0;
         input_e_ack_q  <= 1'b0;
         output_z_q     <= '0;
         output_z_stb_q <= 1'b0;
         mismatch_q     <= 1'b0;
         count_total_q  <= '0;
         count_err_q    <= '0;
      end else begin
         state_q        <= state_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         op_a_stb_q     <= op_a_stb_d;
         op_b_stb_q     <= op_b_stb_d;
         op_z_ack_q     <= op_z_ack_d;
         input_e_ack_q  <= input_e_ack_d;
         output_z_q     <= output_z_d;
         output_z_stb_q <= output_z_stb_d;
         mismatch_q     <= mismatch_d;
         count_total_q  <= count_total_d;
         count_err_q    <= count_err_d;
      end
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_a_stb     = op_a_stb_q;
   assign op_b_stb     = op_b_stb_q;
   assign op_z_ack     = op_z_ack_q;
   assign input_e_ack  = input_e_ack_q;
   assign output_z     = output_z_q;
   assign output_z_stb = output_z_stb_q;
   assign mismatch     = mismatch_q;
   assign count_total  = count_total_q;
   assign count_err    = count_err_q;
   assign busy         = (state_q != IDLE) || !empty_a || !empty_b;

endmodule
`default_nettype wire

// File: tb/tb_fp_stream_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_stream_harness                                         |
// | Description : Self-checking bench for fp_stream_harness. One instance with |
// |               CHECK=1 takes a table of operand/result/expected vectors and |
// |               hand-written stall, split-ack and reset sequences; a second  |
// |               instance with CHECK=0 streams three pairs.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fp_stream_harness;

   localparam int W   = 32;
   localparam int TMO = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [W-1:0]  input_a, input_b, op_z, input_e;
   logic          input_a_stb, input_b_stb, op_a_ack, op_b_ack, op_z_stb, input_e_stb, output_z_ack;
   logic          input_a_ack, input_b_ack, op_a_stb, op_b_stb, op_z_ack, input_e_ack;
   logic          output_z_stb, mismatch, busy;
   logic [W-1:0]  op_a, op_b, output_z;
   logic [31:0]   count_total, count_err;

   logic [W-1:0]  c0_input_a, c0_input_b, c0_op_z, c0_input_e;
   logic          c0_input_a_stb, c0_input_b_stb, c0_op_a_ack, c0_op_b_ack, c0_op_z_stb;
   logic          c0_input_e_stb, c0_output_z_ack;
   logic          c0_input_a_ack, c0_input_b_ack, c0_op_a_stb, c0_op_b_stb, c0_op_z_ack;
   logic          c0_input_e_ack, c0_output_z_stb, c0_mismatch, c0_busy;
   logic [W-1:0]  c0_op_a, c0_op_b, c0_output_z;
   logic [31:0]   c0_count_total, c0_count_err;

   fp_stream_harness #(.WIDTH(W), .DEPTH(4), .CHECK(1'b1)) dut (
      .clk(clk), .rst(rst),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .op_a(op_a), .op_a_stb(op_a_stb), .op_a_ack(op_a_ack),
      .op_b(op_b), .op_b_stb(op_b_stb), .op_b_ack(op_b_ack),
      .op_z(op_z), .op_z_stb(op_z_stb), .op_z_ack(op_z_ack),
      .input_e(input_e), .input_e_stb(input_e_stb), .input_e_ack(input_e_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
      .mismatch(mismatch), .count_total(count_total), .count_err(count_err), .busy(busy)
   );

   fp_stream_harness #(.WIDTH(W), .DEPTH(4), .CHECK(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .input_a(c0_input_a), .input_a_stb(c0_input_a_stb), .input_a_ack(c0_input_a_ack),
      .input_b(c0_input_b), .input_b_stb(c0_input_b_stb), .input_b_ack(c0_input_b_ack),
      .op_a(c0_op_a), .op_a_stb(c0_op_a_stb), .op_a_ack(c0_op_a_ack),
      .op_b(c0_op_b), .op_b_stb(c0_op_b_stb), .op_b_ack(c0_op_b_ack),
      .op_z(c0_op_z), .op_z_stb(c0_op_z_stb), .op_z_ack(c0_op_z_ack),
      .input_e(c0_input_e), .input_e_stb(c0_input_e_stb), .input_e_ack(c0_input_e_ack),
      .output_z(c0_output_z), .output_z_stb(c0_output_z_stb), .output_z_ack(c0_output_z_ack),
      .mismatch(c0_mismatch), .count_total(c0_count_total), .count_err(c0_count_err),
      .busy(c0_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: handshake timed out after %0d cycles", name, TMO);
   endtask

   task automatic push_a(input logic [W-1:0] d);
      int n = 0;
      @(negedge clk);
      input_a = d; input_a_stb = 1'b1;
      while (!input_a_ack && n < TMO) begin @(negedge clk); n++; end
      if (!input_a_ack) timeout("push_a");
      @(negedge clk);
      input_a_stb = 1'b0;
   endtask

   task automatic push_b(input logic [W-1:0] d);
      int n = 0;
      @(negedge clk);
      input_b = d; input_b_stb = 1'b1;
      while (!input_b_ack && n < TMO) begin @(negedge clk); n++; end
      if (!input_b_ack) timeout("push_b");
      @(negedge clk);
      input_b_stb = 1'b0;
   endtask

   task automatic wait_op_stb();
      int n = 0;
      @(negedge clk);
      while (!(op_a_stb && op_b_stb) && n < TMO) begin @(negedge clk); n++; end
      if (!(op_a_stb && op_b_stb)) timeout("op_stb");
   endtask

   task automatic send_z(input logic [W-1:0] z);
      int n = 0;
      op_z = z; op_z_stb = 1'b1;
      while (!op_z_ack && n < TMO) begin @(negedge clk); n++; end
      if (!op_z_ack) timeout("op_z");
      @(negedge clk);
      op_z_stb = 1'b0;
   endtask

   task automatic send_e(input logic [W-1:0] e);
      int n = 0;
      input_e = e; input_e_stb = 1'b1;
      while (!input_e_ack && n < TMO) begin @(negedge clk); n++; end
      if (!input_e_ack) timeout("input_e");
      @(negedge clk);
      input_e_stb = 1'b0;
   endtask

   // Operator model: take both operands together, then return z.
   task automatic serve_op(input logic [W-1:0] z, output logic [W-1:0] ga, output logic [W-1:0] gb);
      wait_op_stb();
      ga = op_a; gb = op_b;
      op_a_ack = 1'b1; op_b_ack = 1'b1;
      @(negedge clk);
      op_a_ack = 1'b0; op_b_ack = 1'b0;
      send_z(z);
   endtask

   task automatic take_out(output logic [W-1:0] z, output logic mm);
      int n = 0;
      while (!output_z_stb && n < TMO) begin @(negedge clk); n++; end
      if (!output_z_stb) timeout("output_z");
      z = output_z; mm = mismatch;
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] a, b, z, e;
      logic         mm;
   } vec_t;

   vec_t         vecs[7];
   logic [W-1:0] ga, gb, oz;
   logic         mm;
   logic [31:0]  exp_total, exp_err;
   logic [W-1:0] fa[5], fb[5], fz[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{a:32'h3FC00000, b:32'h40000000, z:32'h40400000, e:32'h40400000, mm:1'b0};
      vecs[1] = '{a:32'h3FC00000, b:32'h40000000, z:32'h40400000, e:32'h40400001, mm:1'b1};
      vecs[2] = '{a:32'h3FC00000, b:32'h40000000, z:32'h7FC00000, e:32'h7F800001, mm:1'b0};
      vecs[3] = '{a:32'h3F800000, b:32'hBF800000, z:32'h00000000, e:32'h80000000, mm:1'b1};
      vecs[4] = '{a:32'h7F000000, b:32'h7F000000, z:32'h7F800000, e:32'h7F800000, mm:1'b0};
      vecs[5] = '{a:32'h7F000000, b:32'h7F000000, z:32'h7F800000, e:32'h7FC00000, mm:1'b1};
      vecs[6] = '{a:32'h00000000, b:32'h00000000, z:32'h7FC00001, e:32'hFFC00000, mm:1'b0};

      rst = 1'b0;
      input_a = '0; input_b = '0; op_z = '0; input_e = '0;
      input_a_stb = 0; input_b_stb = 0; op_a_ack = 0; op_b_ack = 0;
      op_z_stb = 0; input_e_stb = 0; output_z_ack = 0;
      c0_input_a = '0; c0_input_b = '0; c0_op_z = '0; c0_input_e = '0;
      c0_input_a_stb = 0; c0_input_b_stb = 0; c0_op_a_ack = 0; c0_op_b_ack = 0;
      c0_op_z_stb = 0; c0_input_e_stb = 0; c0_output_z_ack = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_op_a",        op_a, 32'h0);
      check("rst_op_a_stb",    32'(op_a_stb), 32'h0);
      check("rst_op_b_stb",    32'(op_b_stb), 32'h0);
      check("rst_op_z_ack",    32'(op_z_ack), 32'h0);
      check("rst_input_e_ack", 32'(input_e_ack), 32'h0);
      check("rst_output_stb",  32'(output_z_stb), 32'h0);
      check("rst_output_z",    output_z, 32'h0);
      check("rst_count_total", count_total, 32'h0);
      check("rst_busy",        32'(busy), 32'h0);
      check("rst_input_a_ack", 32'(input_a_ack), 32'h1);
      check("rst_input_b_ack", 32'(input_b_ack), 32'h1);
      rst = 1'b1;

      // Table-driven vectors
      exp_total = 0; exp_err = 0;
      for (int i = 0; i < 7; i++) begin
         push_a(vecs[i].a);
         push_b(vecs[i].b);
         serve_op(vecs[i].z, ga, gb);
         send_e(vecs[i].e);
         take_out(oz, mm);
         exp_total = exp_total + 1;
         if (vecs[i].mm) exp_err = exp_err + 1;
         check($sformatf("v%0d_op_a", i),     ga, vecs[i].a);
         check($sformatf("v%0d_op_b", i),     gb, vecs[i].b);
         check($sformatf("v%0d_output_z", i), oz, vecs[i].z);
         check($sformatf("v%0d_mismatch", i), 32'(mm), 32'(vecs[i].mm));
         check($sformatf("v%0d_total", i),    count_total, exp_total);
         check($sformatf("v%0d_err", i),      count_err, exp_err);
      end

      // Split acknowledge: A taken on edge n, B on edge n+2
      push_a(32'h11111111); push_b(32'h22222222);
      push_a(32'h33333333); push_b(32'h44444444);
      wait_op_stb();
      check("split_op_a", op_a, 32'h11111111);
      op_a_ack = 1'b1;
      @(negedge clk);
      op_a_ack = 1'b0;
      check("split_a_stb_n1", 32'(op_a_stb), 32'h0);
      check("split_b_stb_n1", 32'(op_b_stb), 32'h1);
      @(negedge clk);
      check("split_b_stb_n2", 32'(op_b_stb), 32'h1);
      check("split_zack_n2",  32'(op_z_ack), 32'h0);
      op_b_ack = 1'b1;
      @(negedge clk);
      op_b_ack = 1'b0;
      check("split_b_stb_n3", 32'(op_b_stb), 32'h0);
      check("split_zack_n3",  32'(op_z_ack), 32'h1);
      send_z(32'h55555555);
      send_e(32'h55555555);
      take_out(oz, mm);
      check("split_out1", oz, 32'h55555555);
      serve_op(32'h66666666, ga, gb);
      check("split_next_a", ga, 32'h33333333);
      check("split_next_b", gb, 32'h44444444);
      send_e(32'h66666666);
      take_out(oz, mm);
      check("split_out2", oz, 32'h66666666);
      @(negedge clk);
      check("split_busy_end", 32'(busy), 32'h0);
      exp_total = exp_total + 2;
      check("split_total", count_total, exp_total);

      // FIFO full with operator stalled, then drain in order
      for (int i = 0; i < 5; i++) begin
         fa[i] = 32'h41000000 | 32'(i);
         fb[i] = 32'h42000000 | 32'(i << 4);
         fz[i] = 32'h43000000 | 32'(i * 3);
      end
      for (int i = 0; i < 4; i++) push_a(fa[i]);
      check("full_a_ack", 32'(input_a_ack), 32'h0);
      for (int i = 0; i < 4; i++) push_b(fb[i]);
      check("full_b_ack", 32'(input_b_ack), 32'h0);
      check("full_busy",  32'(busy), 32'h1);
      fork
         begin
            push_a(fa[4]);
            push_b(fb[4]);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               serve_op(fz[i], ga, gb);
               check($sformatf("full%0d_op_a", i), ga, fa[i]);
               check($sformatf("full%0d_op_b", i), gb, fb[i]);
               send_e(fz[i]);
               take_out(oz, mm);
               check($sformatf("full%0d_out", i), oz, fz[i]);
            end
         end
      join
      exp_total = exp_total + 5;
      check("full_total", count_total, exp_total);
      check("full_err",   count_err, exp_err);

      // Reset while in WAIT_Z with two pairs queued
      for (int i = 0; i < 3; i++) begin
         push_a(32'h50000000 | 32'(i));
         push_b(32'h60000000 | 32'(i));
      end
      wait_op_stb();
      op_a_ack = 1'b1; op_b_ack = 1'b1;
      @(negedge clk);
      op_a_ack = 1'b0; op_b_ack = 1'b0;
      check("mid_op_z_ack", 32'(op_z_ack), 32'h1);
      check("mid_busy",     32'(busy), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("arst_op_z_ack", 32'(op_z_ack), 32'h0);
      check("arst_op_a",     op_a, 32'h0);
      check("arst_total",    count_total, 32'h0);
      check("arst_err",      count_err, 32'h0);
      check("arst_busy",     32'(busy), 32'h0);
      check("arst_a_ack",    32'(input_a_ack), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_a_ack", 32'(input_a_ack), 32'h1);
      check("post_rst_busy",  32'(busy), 32'h0);
      push_a(vecs[0].a); push_b(vecs[0].b);
      serve_op(vecs[0].z, ga, gb);
      check("post_rst_op_a", ga, vecs[0].a);
      send_e(vecs[0].e);
      take_out(oz, mm);
      check("post_rst_out",   oz, vecs[0].z);
      check("post_rst_total", count_total, 32'h1);

      // CHECK=0 instance: three pairs with expected stream offered throughout
      begin
         int e_seen, mm_seen, out_seen, bad_z;
         e_seen = 0; mm_seen = 0; out_seen = 0; bad_z = 0;
         c0_input_e = 32'hDEADBEEF; c0_input_e_stb = 1'b1;
         c0_op_a_ack = 1'b1; c0_op_b_ack = 1'b1;
         c0_op_z = 32'h40400000; c0_op_z_stb = 1'b1;
         c0_output_z_ack = 1'b1;
         fork
            begin
               for (int i = 0; i < 3; i++) begin
                  @(negedge clk);
                  c0_input_a = 32'h3F800000 + 32'(i);
                  c0_input_b = 32'h40000000 + 32'(i);
                  c0_input_a_stb = 1'b1; c0_input_b_stb = 1'b1;
               end
               @(negedge clk);
               c0_input_a_stb = 1'b0; c0_input_b_stb = 1'b0;
            end
            begin
               for (int c = 0; c < 50; c++) begin
                  @(negedge clk);
                  if (c0_input_e_ack) e_seen++;
                  if (c0_output_z_stb) begin
                     out_seen++;
                     if (c0_mismatch) mm_seen++;
                     if (c0_output_z != 32'h40400000) bad_z++;
                  end
               end
            end
         join
         check("c0_e_ack_cycles",    32'(e_seen), 32'h0);
         check("c0_mismatch_cycles", 32'(mm_seen), 32'h0);
         check("c0_out_cycles",      32'(out_seen), 32'h3);
         check("c0_bad_z",           32'(bad_z), 32'h0);
         check("c0_total",           c0_count_total, 32'h3);
         check("c0_err",             c0_count_err, 32'h0);
         check("c0_busy",            32'(c0_busy), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
